// File: rtl/ps2_key_event_fifo.sv
// PS/2 scan-code decoder: turns the receiver byte stream into make/break/extended
// key events, optionally drops typematic repeats, and queues events for a valid/ready consumer.
module ps2_key_event_fifo #(
  parameter int FIFO_AW         = 2,
  parameter int REPORT_MAKE     = 1,
  parameter int SUPPRESS_REPEAT = 1,
  parameter int TMO_CYCLES      = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [7:0]         rx_data,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_brk,
  output logic               evt_ext,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  input  logic               ovf_clr,
  output logic               busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TMO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  state_t          state, state_n;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            emit_vld;
  evt_t            emit;

  assign busy    = (state != IDLE);
  assign tmo_hit = busy && !rx_done_tick && (tmo_cnt == TW'(TMO_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      tmo_cnt <= (!busy || rx_done_tick) ? '0 : tmo_cnt + 1'b1;
    end
  end

  // E0 always restarts an extended sequence; F0 keeps the extended flag.
  always_comb begin
    state_n  = state;
    emit_vld = 1'b0;
    emit     = '0;
    if (rx_done_tick) begin
      if (rx_data == 8'hE0) begin
        state_n = EXT;
      end else if (rx_data == 8'hF0) begin
        state_n = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        emit_vld  = 1'b1;
        emit.code = rx_data;
        emit.brk  = (state == BRK || state == EXT_BRK);
        emit.ext  = (state == EXT || state == EXT_BRK);
        state_n   = IDLE;
      end
    end else if (tmo_hit) begin
      state_n = IDLE;
    end
  end

  // Repeat filter: last reported make key, invalidated by its own break.
  logic       last_vld;
  logic [8:0] last_key;
  logic       match, rep_drop, push;

  assign match    = last_vld && (last_key == {emit.ext, emit.code});
  assign rep_drop = (SUPPRESS_REPEAT != 0) && !emit.brk && match;
  assign push     = emit_vld && (emit.brk || ((REPORT_MAKE != 0) && !rep_drop));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_vld <= 1'b0;
      last_key <= '0;
    end else if (emit_vld) begin
      if (!emit.brk && !rep_drop) begin
        last_vld <= 1'b1;
        last_key <= {emit.ext, emit.code};
      end else if (emit.brk && match) begin
        last_vld <= 1'b0;
      end
    end
  end

  evt_t               mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               full, pop, wr_en;
  evt_t               head;

  assign full       = (fifo_count == (FIFO_AW+1)'(DEPTH));
  assign evt_valid  = (fifo_count != '0);
  assign pop        = evt_valid && evt_ready;
  assign wr_en      = push && (!full || pop);
  assign head       = mem[rd_ptr];
  assign evt_code   = head.code;
  assign evt_brk    = head.brk;
  assign evt_ext    = head.ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= emit;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A fresh drop outranks a simultaneous clear.
      if (push && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Bench for ps2_key_event_fifo: three filter configurations share one byte stream and
// are compared every cycle against a prefix-flag/list model of the event queue.
module tb_ps2_key_event_fifo;

  localparam int N   = 3;
  localparam int DEP = 4;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset, rx_done_tick, evt_ready, ovf_clr;
  logic [7:0] rx_data;
  logic       vv [N];
  logic [7:0] code [N];
  logic       brk [N], ext [N], ovf [N], busy [N];
  logic [2:0] cnt [N];

  always #5 clk = ~clk;

  // g0: make+break, suppress; g1: breaks only, suppress; g2: make+break, no suppress
  for (genvar g = 0; g < N; g++) begin : g_dut
    ps2_key_event_fifo #(
      .FIFO_AW(2), .REPORT_MAKE(g != 1 ? 1 : 0),
      .SUPPRESS_REPEAT(g != 2 ? 1 : 0), .TMO_CYCLES(TMO)
    ) u (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .evt_valid(vv[g]), .evt_ready(evt_ready), .evt_code(code[g]),
      .evt_brk(brk[g]), .evt_ext(ext[g]), .fifo_count(cnt[g]),
      .overflow(ovf[g]), .ovf_clr(ovf_clr), .busy(busy[g])
    );
  end

  function automatic bit rm(int i); return i != 1; endfunction
  function automatic bit sr(int i); return i != 2; endfunction

  // Model: prefix flags, idle counter, per-instance event list {ext,brk,code}.
  bit         pe, pb;
  int         idle;
  logic [9:0] mq [N][16];
  int         mn [N];
  bit         mov [N], lv [N];
  logic [8:0] lk [N];
  int         errors = 0, checks = 0;
  bit         rdy;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    pe = 0; pb = 0; idle = 0;
    for (int i = 0; i < N; i++) begin mn[i] = 0; mov[i] = 0; lv[i] = 0; lk[i] = '0; end
  endtask

  task automatic model_edge(bit t, logic [7:0] d, bit r, bit c);
    logic [9:0] ev;
    bit ev_v, match, push, pop, drop;
    ev = '0; ev_v = 0;
    if (t) begin
      idle = 0;
      if (d == 8'hE0) begin pe = 1; pb = 0; end
      else if (d == 8'hF0) pb = 1;
      else begin ev = {pe, pb, d}; ev_v = 1; pe = 0; pb = 0; end
    end else if (pe || pb) begin
      idle++;
      if (idle == TMO) begin pe = 0; pb = 0; idle = 0; end
    end else idle = 0;
    for (int i = 0; i < N; i++) begin
      push  = 0;
      match = lv[i] && (lk[i] == {ev[9], ev[7:0]});
      if (ev_v) begin
        if (ev[8]) begin push = 1; if (match) lv[i] = 0; end
        else if (!(sr(i) && match)) begin lk[i] = {ev[9], ev[7:0]}; lv[i] = 1; push = rm(i); end
      end
      pop  = (mn[i] > 0) && r;
      drop = push && (mn[i] == DEP) && !pop;
      if (pop) begin
        for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
        mn[i]--;
      end
      if (push && !drop) begin mq[i][mn[i]] = ev; mn[i]++; end
      if (c) mov[i] = 0;
      if (drop) mov[i] = 1;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid%0d", i), vv[i], mn[i] > 0);
      chk($sformatf("count%0d", i), cnt[i], mn[i]);
      chk($sformatf("overflow%0d", i), ovf[i], mov[i]);
      chk($sformatf("busy%0d", i), busy[i], pe || pb);
      if (mn[i] > 0) chk($sformatf("head%0d", i), {ext[i], brk[i], code[i]}, mq[i][0]);
    end
  endtask

  task automatic cyc(bit t, logic [7:0] d, bit r, bit c);
    rx_done_tick = t; rx_data = d; evt_ready = r; ovf_clr = c;
    model_edge(t, d, r, c);
    @(posedge clk); @(negedge clk);
    check_all();
  endtask

  task automatic send(logic [7:0] d); cyc(1, d, rdy, 0); endtask
  task automatic idle_n(int n); repeat (n) cyc(0, 8'h00, rdy, 0); endtask

  task automatic do_reset();
    reset = 1; rx_done_tick = 0; ovf_clr = 0; evt_ready = 0;
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 0;
    check_all();
  endtask

  logic [7:0] pool [8];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'h1C, 8'h1C, 8'h75, 8'hE1, 8'h23, 8'h00};
    reset = 1; rx_done_tick = 0; rx_data = 0; evt_ready = 0; ovf_clr = 0; rdy = 1;
    @(negedge clk);
    do_reset();
    chk("rst_code", code[0], 8'h00);
    chk("rst_brk_ext", {brk[0], ext[0]}, 2'b00);
    chk("rst_valid", vv[0], 1'b0);

    // Plain make then break, one-cycle latency
    send(8'h1C);
    chk("make_1c", {vv[0], ext[0], brk[0], code[0]}, {1'b1, 1'b0, 1'b0, 8'h1C});
    chk("brkonly_no_make", vv[1], 1'b0);
    idle_n(1);
    send(8'hF0);
    send(8'h1C);
    chk("break_1c", {vv[0], ext[0], brk[0], code[0]}, {1'b1, 1'b0, 1'b1, 8'h1C});
    chk("brkonly_break", {vv[1], brk[1], code[1]}, {1'b1, 1'b1, 8'h1C});
    idle_n(1);

    // Extended make / break
    send(8'hE0);
    chk("busy_ext", busy[0], 1'b1);
    send(8'h75);
    chk("ext_make", {ext[0], brk[0], code[0]}, {1'b1, 1'b0, 8'h75});
    idle_n(1);
    send(8'hE0); send(8'hF0);
    chk("busy_extbrk", busy[0], 1'b1);
    send(8'h75);
    chk("ext_break", {ext[0], brk[0], code[0]}, {1'b1, 1'b1, 8'h75});
    idle_n(1);

    // Typematic repeat suppression
    rdy = 0;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    chk("rep_count", cnt[0], 3'd3);
    chk("rep_brkonly_count", cnt[1], 3'd1);
    rdy = 1; idle_n(5);
    cyc(0, 8'h00, 1, 1);

    // Overflow, clear, push-with-pop on full
    rdy = 0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk("full_count", cnt[0], 3'd4);
    chk("full_ovf", ovf[0], 1'b1);
    chk("full_head", code[0], 8'h15);
    cyc(0, 8'h00, 0, 1);
    chk("ovf_clr", ovf[0], 1'b0);
    cyc(1, 8'h35, 1, 0);
    chk("pushpop_count", cnt[0], 3'd4);
    chk("pushpop_ovf", ovf[0], 1'b0);
    chk("pushpop_head", code[0], 8'h1D);
    rdy = 1; idle_n(5);

    // Prefix timeout
    send(8'hE0);
    idle_n(TMO - 1);
    chk("tmo_still_busy", busy[0], 1'b1);
    idle_n(1);
    chk("tmo_idle", busy[0], 1'b0);
    rdy = 0;
    send(8'h1C);
    chk("tmo_make", {vv[0], ext[0], brk[0], code[0]}, {1'b1, 1'b0, 1'b0, 8'h1C});
    rdy = 1; idle_n(2);

    // Reset mid-sequence
    rdy = 0;
    send(8'h3B); send(8'h4B); send(8'hF0);
    do_reset();
    chk("midrst_state", {vv[0], cnt[0], busy[0]}, 5'b0);
    send(8'h1C);
    chk("midrst_make", {vv[0], brk[0], code[0]}, {1'b1, 1'b0, 8'h1C});

    // Randomised traffic with occasional long gaps
    for (int n = 0; n < 600; n++) begin
      if (n % 100 == 50) idle_n(TMO + 2);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] b;
        b = pool[$urandom_range(0, 7)];
        if (b == 8'h00) b = 8'($urandom_range(0, 255));
        cyc(1, b, rdy, $urandom_range(0, 15) == 0);
      end else begin
        cyc(0, 8'h00, rdy, $urandom_range(0, 15) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
- Parametrised successor to the break-code capture logic in the PS/2 keyboard path.
- Decodes the scan-code byte stream from the PS/2 receiver (rx_done_tick / dout) into key events: make, break, and extended (E0) make/break.
- Optionally suppresses typematic repeats.
- Buffers events in a FIFO drained by a valid/ready handshake. This replaces the single-code "listo" acknowledge scheme.

Parameters:
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW events.
- REPORT_MAKE, 1, 1 = report make and break events; 0 = report break events only.
- SUPPRESS_REPEAT, 1, 1 = drop a make event identical to the last reported make with no intervening break.
- TMO_CYCLES, 2000000, clk cycles a prefix state may idle before it is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_done_tick  in  1  one-cycle strobe: rx_data holds a new received byte
- rx_data  in  8  received scan byte
- evt_valid  out  1  FIFO not empty; head event presented
- evt_ready  in  1  consumer accepts head event
- evt_code  out  8  head event scan code
- evt_brk  out  1  head event is a break (1) / make (0)
- evt_ext  out  1  head event carried an E0 prefix
- fifo_count  out  FIFO_AW+1  number of stored events
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow
- busy  out  1  decoder is in a prefix state (not IDLE)

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high.
  - Reset: FSM to IDLE, FIFO emptied (pointers 0), fifo_count=0, evt_valid=0, evt_code=0, evt_brk=0, evt_ext=0, overflow=0, busy=0, repeat register invalid, timeout counter 0.
  - Reset mid-sequence discards the partial prefix and all stored events.
- Decoder FSM (acts only in cycles with rx_done_tick=1)
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> emit make{ext=0}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; other -> emit make{ext=1} -> IDLE.
  - BRK: F0 -> BRK; E0 -> EXT (restart); other -> emit break{ext=0} -> IDLE.
  - EXT_BRK: F0 -> EXT_BRK; E0 -> EXT; other -> emit break{ext=1} -> IDLE.
  - E1 and all codes other than E0/F0 are treated as ordinary codes.
  - busy = (state != IDLE).
- Timeout
  - Counter increments each cycle in a non-IDLE state without rx_done_tick. It resets on any byte or in IDLE.
  - When the counter reaches TMO_CYCLES-1, the FSM returns to IDLE next edge. No event is emitted.
- Event filtering
  - REPORT_MAKE=0: make events are not pushed. Repeat tracking still updates.
  - SUPPRESS_REPEAT=1: register last={ext,code,vld}.
    - Make matching last with vld=1 is dropped.
    - Any other make sets last and vld=1.
    - Break matching {ext,code} clears vld.
    - Non-matching break leaves last unchanged.
- FIFO and handshake
  - An emitted, unfiltered event is written at the clk edge ending the rx_done_tick cycle. It is visible on evt_* / evt_valid one cycle later if the FIFO was empty. Latency = 1 cycle.
  - Pop occurs on an edge where evt_valid && evt_ready. evt_* shows the head event; it holds stable while evt_valid=1 and evt_ready=0.
  - evt_* values are don't-care when evt_valid=0. They hold the last value; they are not required to be 0.
  - Push while full with no pop: event dropped, overflow set next edge.
  - Push while full with simultaneous pop: both take effect, no drop, count unchanged.
  - Push and pop on an empty FIFO: no pop, because evt_valid=0. The push lands.
  - Pointers wrap modulo 2^FIFO_AW. fifo_count ranges 0..2^FIFO_AW.
  - ovf_clr clears overflow. If ovf_clr and a new drop occur in the same cycle, overflow stays 1 (set wins).

Test Plan:
- Bytes 1C, F0 1C with evt_ready=1 -> events {1C,brk0,ext0}, {1C,brk1,ext0}; each evt_valid one cycle after its final byte's tick.
- Bytes E0 75, E0 F0 75 -> {75,0,1}, {75,1,1}; busy high between prefix and final byte.
- SUPPRESS_REPEAT=1: 1C,1C,1C,F0 1C,1C -> exactly make, break, make; with REPORT_MAKE=0 only the break.
- FIFO_AW=2, evt_ready=0: send 5 distinct makes -> fifo_count=4, overflow=1, head = first code. Pulse ovf_clr -> overflow=0. Push with pop on full -> count stays 4, no overflow.
- TMO_CYCLES=16: send E0, idle 16 cycles, send 1C -> busy drops after timeout; event {1C,0,0}.
- Assert reset after F0 with 2 events queued -> evt_valid=0, fifo_count=0, busy=0. Then 1C -> make event, not break.
